// File: rtl/main_mem_pkg.sv
// Shared types and sizing helpers for the
// block-transfer main memory.
package main_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  function automatic int off_bits(input int block_words);
    return $clog2(block_words) + 2;
  endfunction

  function automatic int cnt_width(input int latency);
    return (latency < 2) ? 1 : $clog2(latency);
  endfunction

endpackage

// File: rtl/main_mem_array.sv
// Word-masked block-wide storage with a
// combinational post-write view of the block.
import main_mem_pkg::*;

module main_mem_array #(
  parameter int ADDR_W      = 10,
  parameter int WORD_W      = 32,
  parameter int BLOCK_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [ADDR_W-off_bits(BLOCK_WORDS)-1:0] blk,
  input  logic [BLOCK_WORDS*WORD_W-1:0] wdata,
  input  logic [BLOCK_WORDS-1:0]        wmask,
  output logic [BLOCK_WORDS*WORD_W-1:0] rdata
);

  localparam int WB    = $clog2(BLOCK_WORDS);
  localparam int IW    = ADDR_W - 2;
  localparam int DEPTH = 2 ** IW;
  localparam int BLK_W = ADDR_W - off_bits(BLOCK_WORDS);

  logic [WORD_W-1:0] mem [DEPTH] = '{default: '0};

  function automatic logic [IW-1:0] word_idx(
    input logic [BLK_W-1:0] b,
    input int               k
  );
    return (IW'(b) << WB) | IW'(k);
  endfunction

  // Block as it looks after this edge's write
  always_comb begin
    rdata = '0;
    for (int k = 0; k < BLOCK_WORDS; k++) begin
      if (we && wmask[k])
        rdata[k*WORD_W +: WORD_W] = wdata[k*WORD_W +: WORD_W];
      else
        rdata[k*WORD_W +: WORD_W] = mem[word_idx(blk, k)];
    end
  end

  // Masked per-word store
  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < BLOCK_WORDS; k++) begin
        if (wmask[k])
          mem[word_idx(blk, k)] <= wdata[k*WORD_W +: WORD_W];
      end
    end
  end

endmodule

// File: rtl/main_memory_ctrl.sv
// Block-transfer main memory: valid/ready request,
// fixed programmable latency, one-cycle response.
import main_mem_pkg::*;

module main_memory_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int WORD_W      = 32,
  parameter int BLOCK_WORDS = 4,
  parameter int LATENCY     = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [BLOCK_WORDS*WORD_W-1:0] req_wdata,
  input  logic [BLOCK_WORDS-1:0]        req_wmask,
  output logic                          resp_valid,
  output logic [BLOCK_WORDS*WORD_W-1:0] resp_rdata
);

  localparam int OFF   = off_bits(BLOCK_WORDS);
  localparam int BLK_W = ADDR_W - OFF;
  localparam int CW    = cnt_width(LATENCY);

  if (LATENCY < 1 || BLOCK_WORDS < 1 ||
      (BLOCK_WORDS & (BLOCK_WORDS - 1)) != 0) begin : g_bad_param
    $error("main_memory_ctrl: illegal LATENCY or BLOCK_WORDS");
  end

  state_t                        state;
  logic [CW-1:0]                 cnt;
  logic                          wr_q;
  logic [BLK_W-1:0]              blk_q;
  logic [BLOCK_WORDS*WORD_W-1:0] wdata_q;
  logic [BLOCK_WORDS-1:0]        wmask_q;
  logic [BLOCK_WORDS*WORD_W-1:0] arr_rdata;
  logic                          commit;
  logic                          unused_off;

  assign unused_off = ^req_addr[OFF-1:0];
  assign commit     = (state == BUSY) && (cnt == '0);

  main_mem_array #(
    .ADDR_W      (ADDR_W),
    .WORD_W      (WORD_W),
    .BLOCK_WORDS (BLOCK_WORDS)
  ) u_array (
    .clk   (clk),
    .we    (commit && wr_q),
    .blk   (blk_q),
    .wdata (wdata_q),
    .wmask (wmask_q),
    .rdata (arr_rdata)
  );

  // Request capture, latency count and response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      wr_q       <= 1'b0;
      blk_q      <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            wr_q      <= req_write;
            blk_q     <= req_addr[ADDR_W-1:OFF];
            wdata_q   <= req_wdata;
            wmask_q   <= req_wmask;
            cnt       <= CW'(LATENCY - 1);
            req_ready <= 1'b0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            resp_rdata <= arr_rdata;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
